// File: rtl/hamming_tx_sequencer.sv
// Byte-stream front end for the Hamming(7,4) encoder: splits each accepted byte
// into two nibbles (low first) and emits one codeword per nibble, framed into blocks.

module hamming_encode (
    input  logic [3:0] data_i,
    output logic [6:0] data_o
);
    // Codeword bit k holds Hamming position k+1: parity at positions 1,2,4, data at 3,5,6,7.
    assign data_o[0] = data_i[0] ^ data_i[1] ^ data_i[3];
    assign data_o[1] = data_i[0] ^ data_i[2] ^ data_i[3];
    assign data_o[2] = data_i[0];
    assign data_o[3] = data_i[1] ^ data_i[2] ^ data_i[3];
    assign data_o[4] = data_i[1];
    assign data_o[5] = data_i[2];
    assign data_o[6] = data_i[3];
endmodule

module hamming_tx_sequencer #(
    parameter int BLOCK_BYTES = 16,
    parameter int CNT_W       = $clog2(BLOCK_BYTES) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [6:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             busy
);
    // Handshake: a transfer occurs on a rising clk edge where valid and ready are both high.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t           r_state;
    logic [7:0]       r_byte;
    logic [CNT_W-1:0] r_byte_cnt;
    logic             r_rst_done;

    logic             w_is_lo;
    logic             w_is_hi;
    logic             w_block_end;
    logic [3:0]       w_nibble;
    logic [6:0]       w_code;

    assign w_is_lo     = (r_state == SEND_LO);
    assign w_is_hi     = (r_state == SEND_HI);
    assign w_block_end = (r_byte_cnt == CNT_W'(BLOCK_BYTES - 1));
    assign w_nibble    = w_is_hi ? r_byte[7:4] : r_byte[3:0];

    hamming_encode u_enc (
        .data_i (w_nibble),
        .data_o (w_code)
    );

    assign m_valid  = w_is_lo | w_is_hi;
    assign m_data   = m_valid ? w_code : 7'd0;
    assign m_last   = w_is_hi & w_block_end;
    assign byte_cnt = r_byte_cnt;
    assign busy     = (r_state != IDLE);

    // In SEND_HI the next byte may enter in the same cycle the high codeword leaves,
    // which keeps the stream bubble-free while never dropping a byte during a stall.
    always_comb begin
        s_ready = 1'b0;
        case (r_state)
            IDLE:    s_ready = r_rst_done;
            SEND_HI: s_ready = m_ready;
            default: s_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte     <= 8'd0;
            r_byte_cnt <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (s_valid && r_rst_done) begin
                        r_byte  <= s_data;
                        r_state <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (m_ready) begin
                        r_state <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (m_ready) begin
                        r_byte_cnt <= w_block_end ? '0 : r_byte_cnt + CNT_W'(1);
                        if (s_valid) begin
                            r_byte  <= s_data;
                            r_state <= SEND_LO;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hamming_tx_sequencer.sv
// Randomized self-checking bench for hamming_tx_sequencer with a positional Hamming
// reference model and a negedge scoreboard that rebuilds the byte stream from codewords.

module tb_hamming_tx_sequencer;
    localparam int BLOCK_BYTES = 16;
    localparam int CNT_W       = $clog2(BLOCK_BYTES) + 1;

    logic             clk;
    logic             rst;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic [6:0]       m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [CNT_W-1:0] byte_cnt;
    logic             busy;

    int errors = 0;
    int checks = 0;

    hamming_tx_sequencer #(.BLOCK_BYTES(BLOCK_BYTES)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .byte_cnt (byte_cnt),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder: place data at positions 3,5,6,7 and set each parity
    // position p so the XOR over all positions having bit p set is zero.
    function automatic logic [6:0] ref_enc(input logic [3:0] d);
        logic [7:0] pos;
        pos    = 8'd0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int p = 1; p <= 4; p = p * 2)
            for (int i = 3; i <= 7; i++)
                if (((i & p) != 0) && (i != p)) pos[p] = pos[p] ^ pos[i];
        return pos[7:1];
    endfunction

    // Syndrome decoder: XOR of the positions of set bits names the flipped bit.
    function automatic logic [3:0] ref_dec(input logic [6:0] c);
        logic [6:0] cw;
        int syn;
        cw  = c;
        syn = 0;
        for (int i = 1; i <= 7; i++)
            if (cw[i-1]) syn = syn ^ i;
        if (syn != 0) cw[syn-1] = ~cw[syn-1];
        return {cw[6], cw[5], cw[4], cw[2]};
    endfunction

    // Scoreboard state: {hi, last, code} per expected codeword, bytes in acceptance order.
    logic [8:0] exp_q[$];
    logic [7:0] in_q[$];
    int         bytes_in   = 0;
    int         bytes_done = 0;
    int         recon_n    = 0;
    logic [3:0] lo_nib     = 4'd0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_q.delete();
            bytes_in   = 0;
            bytes_done = 0;
            recon_n    = 0;
        end else begin
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_cw got=%h expected none", m_data);
                end else begin
                    logic [8:0] e;
                    int         exp_cnt;
                    e       = exp_q.pop_front();
                    exp_cnt = bytes_done % BLOCK_BYTES;
                    if (m_data !== e[6:0] || m_last !== e[7] || byte_cnt !== CNT_W'(exp_cnt)) begin
                        errors++;
                        $display("FAIL sb_codeword got data=%h last=%b cnt=%0d exp data=%h last=%b cnt=%0d",
                                 m_data, m_last, byte_cnt, e[6:0], e[7], exp_cnt);
                    end
                    if (!e[8]) begin
                        lo_nib = ref_dec(m_data);
                    end else begin
                        logic [7:0] rb;
                        logic [7:0] xb;
                        bytes_done++;
                        rb = {ref_dec(m_data), lo_nib};
                        xb = (in_q.size() != 0) ? in_q.pop_front() : 8'hxx;
                        recon_n++;
                        checks++;
                        if (rb !== xb) begin
                            errors++;
                            $display("FAIL sb_reconstruct got=%h exp=%h", rb, xb);
                        end
                    end
                end
            end
            if (s_valid && s_ready) begin
                in_q.push_back(s_data);
                exp_q.push_back({1'b0, 1'b0, ref_enc(s_data[3:0])});
                exp_q.push_back({1'b1, ((bytes_in % BLOCK_BYTES) == BLOCK_BYTES - 1), ref_enc(s_data[7:4])});
                bytes_in++;
            end
        end
    end

    // Drive inputs just after a rising edge, return just after the following falling edge.
    task automatic cyc(input logic sv, input logic [7:0] sd, input logic mr);
        @(posedge clk);
        #1;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || byte_cnt !== '0 ||
            m_last !== 1'b0 || m_data !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b cnt=%0d last=%b data=%h exp all 0",
                     s_ready, m_valid, busy, byte_cnt, m_last, m_data);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready got=%b exp=0", s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_edge got rdy=%b busy=%b exp rdy=1 busy=0", s_ready, busy);
        end
    endtask

    task automatic test_single;
        cyc(1'b1, 8'hA5, 1'b1);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle got rdy=%b vld=%b exp rdy=1 vld=0", s_ready, m_valid);
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== ref_enc(4'h5) || m_last !== 1'b0 || s_ready !== 1'b0 ||
            busy !== 1'b1) begin
            errors++;
            $display("FAIL single_lo got vld=%b data=%h last=%b rdy=%b exp vld=1 data=%h last=0 rdy=0",
                     m_valid, m_data, m_last, s_ready, ref_enc(4'h5));
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== ref_enc(4'hA) || ref_dec(m_data) !== 4'hA || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_hi got vld=%b data=%h rdy=%b exp vld=1 data=%h rdy=1",
                     m_valid, m_data, s_ready, ref_enc(4'hA));
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (m_valid !== 1'b0 || m_data !== 7'd0 || busy !== 1'b0 || byte_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL single_done got vld=%b data=%h busy=%b cnt=%0d exp 0 0 0 1",
                     m_valid, m_data, busy, byte_cnt);
        end
    endtask

    task automatic test_stream;
        int idx = 0, ncw = 0, nlast = 0, last_at = -1, first = -1, lastc = -1;
        logic [CNT_W-1:0] cnt_at_last = '0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            cyc(idx < 16, idx[7:0], 1'b1);
            if (m_valid) begin
                ncw++;
                if (first < 0) first = c;
                lastc = c;
                if (m_last) begin
                    nlast++;
                    last_at     = ncw;
                    cnt_at_last = byte_cnt;
                end
            end
            if (s_valid && s_ready) idx++;
        end
        checks++;
        if (ncw != 32 || (lastc - first + 1) != 32) begin
            errors++;
            $display("FAIL stream_throughput got cw=%0d span=%0d exp 32 32", ncw, lastc - first + 1);
        end
        checks++;
        if (nlast != 1 || last_at != 32 || cnt_at_last !== CNT_W'(15)) begin
            errors++;
            $display("FAIL stream_last got n=%0d at=%0d cnt=%0d exp 1 32 15", nlast, last_at, cnt_at_last);
        end
        checks++;
        if (byte_cnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stream_wrap got cnt=%0d busy=%b exp 0 0", byte_cnt, busy);
        end
    endtask

    task automatic test_backpressure;
        cyc(1'b1, 8'h3C, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'h96, 1'b0);
            checks++;
            if (m_valid !== 1'b1 || m_data !== ref_enc(4'hC) || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_lo_stall got vld=%b data=%h rdy=%b exp 1 %h 0", m_valid, m_data, s_ready, ref_enc(4'hC));
            end
        end
        cyc(1'b1, 8'h96, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 8'h96, 1'b0);
            checks++;
            if (m_valid !== 1'b1 || m_data !== ref_enc(4'h3) || s_ready !== 1'b0 || byte_cnt !== '0) begin
                errors++;
                $display("FAIL bp_hi_stall got vld=%b data=%h rdy=%b cnt=%0d exp 1 %h 0 0",
                         m_valid, m_data, s_ready, byte_cnt, ref_enc(4'h3));
            end
        end
        cyc(1'b1, 8'h96, 1'b1);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got=%b exp=1", s_ready);
        end
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (m_valid !== 1'b1 || m_data !== ref_enc(4'h6)) begin
            errors++;
            $display("FAIL bp_no_bubble got vld=%b data=%h exp 1 %h", m_valid, m_data, ref_enc(4'h6));
        end
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        checks++;
        if (busy !== 1'b0 || byte_cnt !== CNT_W'(2) || in_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain got busy=%b cnt=%0d pend_in=%0d pend_cw=%0d exp 0 2 0 0",
                     busy, byte_cnt, in_q.size(), exp_q.size());
        end
    endtask

    task automatic test_idle_gap;
        int sent = 0, gap = 0, ncw = 0, nlast = 0, last_at = -1;
        logic [7:0] cur;
        logic       want;
        do_reset();
        cur = 8'($urandom);
        for (int c = 0; c < 300; c++) begin
            want = (sent < 10) || (gap >= 22 && sent < 16);
            cyc(want, cur, 1'b1);
            if (m_valid && m_ready) begin
                ncw++;
                if (m_last) begin
                    nlast++;
                    last_at = ncw;
                end
            end
            if (s_valid && s_ready) begin
                sent++;
                cur = 8'($urandom);
            end else if (sent == 10 && !s_valid) begin
                gap++;
            end
            if (sent == 16 && !busy) break;
        end
        checks++;
        if (sent != 16 || busy !== 1'b0) begin
            errors++;
            $display("FAIL gap_timeout got sent=%0d busy=%b exp 16 0", sent, busy);
        end
        checks++;
        if (nlast != 1 || last_at != 32 || byte_cnt !== '0) begin
            errors++;
            $display("FAIL gap_last got n=%0d at=%0d cnt=%0d exp 1 32 0", nlast, last_at, byte_cnt);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        for (int b = 0; b < 15; b++) begin
            cyc(1'b1, 8'(b * 17), 1'b1);
            cyc(1'b0, 8'h00, 1'b1);
            cyc(1'b0, 8'h00, 1'b1);
        end
        cyc(1'b1, 8'h5A, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        checks++;
        if (m_last !== 1'b1 || busy !== 1'b1 || byte_cnt !== CNT_W'(15)) begin
            errors++;
            $display("FAIL rmid_setup got last=%b busy=%b cnt=%0d exp 1 1 15", m_last, busy, byte_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || byte_cnt !== '0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async got vld=%b last=%b busy=%b cnt=%0d rdy=%b exp all 0",
                     m_valid, m_last, busy, byte_cnt, s_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rmid_release_ready got=%b exp=0", s_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmid_first_edge got rdy=%b busy=%b exp 1 0", s_ready, busy);
        end
    endtask

    task automatic test_exhaustive;
        int         nxt = 0;
        logic       holding = 1'b0;
        logic       mr;
        logic       prev_stall = 1'b0;
        logic [6:0] pd = 7'd0;
        logic       pl = 1'b0;
        logic [CNT_W-1:0] pc = '0;
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            if (!holding && nxt < 256) holding = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 3) != 0);
            cyc(holding, nxt[7:0], mr);
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl || byte_cnt !== pc) begin
                    errors++;
                    $display("FAIL exh_stall_hold got vld=%b data=%h last=%b cnt=%0d exp 1 %h %b %0d",
                             m_valid, m_data, m_last, byte_cnt, pd, pl, pc);
                end
            end
            prev_stall = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            pc = byte_cnt;
            if (s_valid && s_ready) begin
                nxt++;
                holding = 1'b0;
            end
            if (nxt == 256 && !busy && !holding) break;
        end
        checks++;
        if (nxt != 256 || busy !== 1'b0) begin
            errors++;
            $display("FAIL exh_timeout got sent=%0d busy=%b exp 256 0", nxt, busy);
        end
        checks++;
        if (recon_n != 256 || in_q.size() != 0 || exp_q.size() != 0 || byte_cnt !== '0) begin
            errors++;
            $display("FAIL exh_complete got recon=%0d pend_in=%0d pend_cw=%0d cnt=%0d exp 256 0 0 0",
                     recon_n, in_q.size(), exp_q.size(), byte_cnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_idle_gap();
        test_reset_mid();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
